// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment glyph constants and helpers
package seg_pkg;

   // Common-cathode glyphs, bit0 = segment a ... bit6 = segment g
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   localparam logic [7:0] SEG_OFF_CC = 8'h00;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - display data in, scanned pins out
interface seg_scan_driver_if #(
   parameter int DIGITS = 6
);
   logic                  en;
   logic [4*DIGITS-1:0]   hex_data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     blank;
   logic                  lz_en;
   logic [3:0]            bright;
   logic [7:0]            seg_data;
   logic [DIGITS-1:0]     seg_cs;
   logic                  frame_sync;

   modport master (
      output en, hex_data, dp, blank, lz_en, bright,
      input  seg_data, seg_cs, frame_sync
   );

   modport slave (
      input  en, hex_data, dp, blank, lz_en, bright,
      output seg_data, seg_cs, frame_sync
   );
endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - hex nibble to common-cathode seven-segment glyph
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_0;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed N-digit seven-segment scan driver
// with prescaler, PWM brightness, leading-zero suppression and frame snapshot.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int CLK_DIV        = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int CS_ACTIVE_LOW  = 1
) (
   input  logic              clk,
   input  logic              rst_,
   seg_scan_driver_if.slave  bus
);

   localparam int DIV_W = clog2(CLK_DIV);
   localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
   localparam int ON_W  = DIV_W + 5;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF_CC : SEG_OFF_CC;
   localparam logic [DIGITS-1:0] CS_IDLE  = (CS_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic                slot_end;
   logic                frame_end;

   logic [4*DIGITS-1:0] snap_hex;
   logic [DIGITS-1:0]   snap_dp;
   logic [DIGITS-1:0]   snap_blank;
   logic                snap_lz;
   logic [3:0]          snap_bright;
   logic                snap_en;

   logic [ON_W-1:0]     on_prod;
   logic [ON_W-1:0]     on_len;
   logic [DIGITS-1:0]   lz_dark;
   logic                all_zero;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic                cur_lzd;
   logic [6:0]          glyph;
   logic                lit;
   logic [7:0]          seg_cc;
   logic [DIGITS-1:0]   cs_act;

   logic [7:0]          seg_q;
   logic [DIGITS-1:0]   cs_q;
   logic                fs_q;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (slot_end) begin
         div_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // The display always shows a coherent frame: inputs are only sampled at the wrap.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         snap_hex    <= '0;
         snap_dp     <= '0;
         snap_blank  <= '0;
         snap_lz     <= 1'b0;
         snap_bright <= '0;
         snap_en     <= 1'b0;
      end else if (frame_end) begin
         snap_hex    <= bus.hex_data;
         snap_dp     <= bus.dp;
         snap_blank  <= bus.blank;
         snap_lz     <= bus.lz_en;
         snap_bright <= bus.bright;
         snap_en     <= bus.en;
      end
   end

   assign on_prod = (ON_W'(snap_bright) + ON_W'(1)) * ON_W'(CLK_DIV);
   assign on_len  = on_prod >> 4;

   always_comb begin
      lz_dark  = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero   = all_zero && (snap_hex[4*i +: 4] == 4'h0);
         lz_dark[i] = snap_lz && all_zero;
      end
   end

   assign cur_nib   = 4'(snap_hex >> {idx, 2'b00});
   assign cur_dp    = 1'(snap_dp >> idx);
   assign cur_blank = 1'(snap_blank >> idx);
   assign cur_lzd   = 1'(lz_dark >> idx);

   seg_hex_decode u_dec (
      .hex (cur_nib),
      .seg (glyph)
   );

   // div_cnt == 0 stays dark so the previous digit's select has settled off.
   assign lit = snap_en
             && (div_cnt != '0)
             && (ON_W'(div_cnt) <= on_len)
             && !cur_blank
             && !(cur_lzd && !cur_dp);

   always_comb begin
      seg_cc = SEG_OFF_CC;
      cs_act = '0;
      if (lit) begin
         seg_cc = {cur_dp, cur_lzd ? 7'h00 : glyph};
         cs_act = DIGITS'(1) << idx;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         seg_q <= SEG_IDLE;
         cs_q  <= CS_IDLE;
         fs_q  <= 1'b0;
      end else begin
         seg_q <= (SEG_ACTIVE_LOW != 0) ? ~seg_cc : seg_cc;
         cs_q  <= (CS_ACTIVE_LOW != 0) ? ~cs_act : cs_act;
         fs_q  <= frame_end;
      end
   end

   assign bus.seg_data   = seg_q;
   assign bus.seg_cs     = cs_q;
   assign bus.frame_sync = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed bench for seg_scan_driver (DIGITS=6, CLK_DIV=16)
module tb_seg_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_;
   logic rst_b_;

   seg_scan_driver_if #(.DIGITS(6)) bus_a ();
   seg_scan_driver_if #(.DIGITS(6)) bus_b ();

   seg_scan_driver #(.DIGITS(6), .CLK_DIV(16), .SEG_ACTIVE_LOW(1), .CS_ACTIVE_LOW(1)) dut_a (
      .clk (clk), .rst_ (rst_a_), .bus (bus_a.slave)
   );

   seg_scan_driver #(.DIGITS(6), .CLK_DIV(16), .SEG_ACTIVE_LOW(0), .CS_ACTIVE_LOW(0)) dut_b (
      .clk (clk), .rst_ (rst_b_), .bus (bus_b.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [5:0] cs_s   [0:191];
   logic [7:0] seg_s  [0:191];
   logic [5:0] csb_s  [0:191];
   logic [7:0] segb_s [0:191];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sample k of a capture started right after a frame_sync reflects idx=k/16, div_cnt=k%16.
   task automatic capture(input int start, input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         cs_s[start+k]   = bus_a.seg_cs;
         seg_s[start+k]  = bus_a.seg_data;
         csb_s[start+k]  = bus_b.seg_cs;
         segb_s[start+k] = bus_b.seg_data;
      end
   endtask

   task automatic wait_fs();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (bus_a.frame_sync === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL wait_fs: frame_sync got 0 within 300 cycles, want 1"); end
   endtask

   function automatic int lit_count(input int slot, input logic [5:0] want_cs, input logic [7:0] want_seg);
      int c;
      c = 0;
      for (int k = slot*16; k < slot*16 + 16; k++)
         if (cs_s[k] === want_cs && seg_s[k] === want_seg) c++;
      return c;
   endfunction

   function automatic int sel_count(input int first, input int last);
      int c;
      c = 0;
      for (int k = first; k <= last; k++)
         if (cs_s[k] !== 6'h3F) c++;
      return c;
   endfunction

   task automatic test_reset();
      int first_fs, first_sel, fs97;
      logic [5:0] sel_cs;
      logic [7:0] sel_seg;
      rst_a_ = 1'b0; rst_b_ = 1'b0;
      bus_a.en = 1'b1; bus_a.hex_data = 24'h123456; bus_a.dp = '0; bus_a.blank = '0;
      bus_a.lz_en = 1'b0; bus_a.bright = 4'd15;
      bus_b.en = 1'b1; bus_b.hex_data = 24'h000008; bus_b.dp = '0; bus_b.blank = '0;
      bus_b.lz_en = 1'b0; bus_b.bright = 4'd15;
      tick(); tick(); tick();
      n_cmp++; if (bus_a.seg_cs !== 6'b111111) begin n_bad++; $display("FAIL reset_cs: got %b want 111111", bus_a.seg_cs); end
      n_cmp++; if (bus_a.seg_data !== 8'hFF) begin n_bad++; $display("FAIL reset_seg: got %h want ff", bus_a.seg_data); end
      n_cmp++; if (bus_a.frame_sync !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b want 0", bus_a.frame_sync); end
      n_cmp++; if (bus_b.seg_cs !== 6'b000000) begin n_bad++; $display("FAIL reset_cs_b: got %b want 000000", bus_b.seg_cs); end
      n_cmp++; if (bus_b.seg_data !== 8'h00) begin n_bad++; $display("FAIL reset_seg_b: got %h want 00", bus_b.seg_data); end
      rst_a_ = 1'b1; rst_b_ = 1'b1;
      first_fs = -1; first_sel = -1; fs97 = -1; sel_cs = '0; sel_seg = '0;
      for (int e = 1; e <= 120; e++) begin
         tick();
         if (bus_a.frame_sync === 1'b1 && first_fs < 0) first_fs = e;
         if (e == 97) fs97 = int'(bus_a.frame_sync);
         if (bus_a.seg_cs !== 6'b111111 && first_sel < 0) begin
            first_sel = e; sel_cs = bus_a.seg_cs; sel_seg = bus_a.seg_data;
         end
      end
      n_cmp++; if (first_fs != 96) begin n_bad++; $display("FAIL first_fs_cycle: got %0d want 96", first_fs); end
      n_cmp++; if (fs97 != 0) begin n_bad++; $display("FAIL fs_one_cycle: got %0d want 0", fs97); end
      n_cmp++; if (first_sel != 98) begin n_bad++; $display("FAIL first_sel_cycle: got %0d want 98", first_sel); end
      n_cmp++; if (sel_cs !== 6'b111110) begin n_bad++; $display("FAIL first_sel_cs: got %b want 111110", sel_cs); end
      n_cmp++; if (sel_seg !== 8'h82) begin n_bad++; $display("FAIL first_sel_seg: got %h want 82", sel_seg); end
   endtask

   task automatic test_scan_order();
      logic [7:0] exp_seg [0:5];
      int c;
      exp_seg[0] = 8'h82; exp_seg[1] = 8'h92; exp_seg[2] = 8'h99;
      exp_seg[3] = 8'hB0; exp_seg[4] = 8'hA4; exp_seg[5] = 8'hF9;
      bus_a.hex_data = 24'h123456; bus_a.bright = 4'd15;
      wait_fs();
      capture(0, 96);
      for (int i = 0; i < 6; i++) begin
         c = lit_count(i, ~(6'b000001 << i), exp_seg[i]);
         n_cmp++; if (c != 15) begin n_bad++; $display("FAIL scan_lit_d%0d: got %0d lit cycles want 15", i, c); end
         n_cmp++; if (cs_s[16*i] !== 6'h3F || seg_s[16*i] !== 8'hFF) begin
            n_bad++; $display("FAIL scan_dead_d%0d: got cs=%b seg=%h want cs=111111 seg=ff", i, cs_s[16*i], seg_s[16*i]);
         end
      end
   endtask

   task automatic test_lz();
      logic [7:0] exp_seg [0:3];
      int c;
      exp_seg[0] = 8'hC0; exp_seg[1] = 8'hA4; exp_seg[2] = 8'hF9; exp_seg[3] = 8'h7F;
      bus_a.hex_data = 24'h000120; bus_a.lz_en = 1'b1; bus_a.dp = 6'b001000;
      wait_fs();
      capture(0, 96);
      for (int i = 0; i < 4; i++) begin
         c = lit_count(i, ~(6'b000001 << i), exp_seg[i]);
         n_cmp++; if (c != 15) begin n_bad++; $display("FAIL lz_lit_d%0d: got %0d lit cycles want 15", i, c); end
      end
      c = sel_count(64, 95);
      n_cmp++; if (c != 0) begin n_bad++; $display("FAIL lz_dark_d45: got %0d selected cycles want 0", c); end
      bus_a.lz_en = 1'b0; bus_a.dp = '0;
   endtask

   task automatic test_pwm();
      int c;
      bus_a.hex_data = 24'h123456; bus_a.bright = 4'd3;
      wait_fs();
      capture(0, 96);
      c = lit_count(0, 6'b111110, 8'h82);
      n_cmp++; if (c != 4) begin n_bad++; $display("FAIL pwm3_count: got %0d want 4", c); end
      n_cmp++; if (cs_s[4] !== 6'b111110) begin n_bad++; $display("FAIL pwm3_last_on: got %b want 111110", cs_s[4]); end
      n_cmp++; if (cs_s[5] !== 6'b111111) begin n_bad++; $display("FAIL pwm3_first_off: got %b want 111111", cs_s[5]); end
      bus_a.bright = 4'd0;
      wait_fs();
      capture(0, 96);
      c = lit_count(0, 6'b111110, 8'h82);
      n_cmp++; if (c != 1) begin n_bad++; $display("FAIL pwm0_count: got %0d want 1", c); end
      n_cmp++; if (cs_s[1] !== 6'b111110 || cs_s[2] !== 6'b111111) begin
         n_bad++; $display("FAIL pwm0_window: got %b,%b want 111110,111111", cs_s[1], cs_s[2]);
      end
      c = lit_count(5, 6'b011111, 8'hF9);
      n_cmp++; if (c != 1) begin n_bad++; $display("FAIL pwm0_count_d5: got %0d want 1", c); end
      bus_a.bright = 4'd15;
   endtask

   task automatic test_snapshot_blank();
      int c;
      bus_a.hex_data = 24'h123456; bus_a.blank = '0;
      wait_fs();
      capture(0, 40);
      bus_a.hex_data = 24'hABCDEF; bus_a.blank = 6'b000100;
      capture(40, 56);
      capture(96, 96);
      c = lit_count(2, 6'b111011, 8'h99);
      n_cmp++; if (c != 15) begin n_bad++; $display("FAIL snap_old_d2: got %0d want 15", c); end
      c = lit_count(3, 6'b110111, 8'hB0);
      n_cmp++; if (c != 15) begin n_bad++; $display("FAIL snap_old_d3: got %0d want 15", c); end
      c = lit_count(5, 6'b011111, 8'hF9);
      n_cmp++; if (c != 15) begin n_bad++; $display("FAIL snap_old_d5: got %0d want 15", c); end
      c = lit_count(6, 6'b111110, 8'h8E);
      n_cmp++; if (c != 15) begin n_bad++; $display("FAIL snap_new_d0: got %0d want 15", c); end
      c = sel_count(128, 143);
      n_cmp++; if (c != 0) begin n_bad++; $display("FAIL blank_d2: got %0d selected want 0", c); end
      c = lit_count(9, 6'b110111, 8'hC6);
      n_cmp++; if (c != 15) begin n_bad++; $display("FAIL snap_new_d3: got %0d want 15", c); end
      bus_a.blank = '0; bus_a.hex_data = 24'h123456;
   endtask

   task automatic test_enable();
      int c;
      bus_a.en = 1'b0;
      wait_fs();
      capture(0, 96);
      c = sel_count(0, 95);
      n_cmp++; if (c != 0) begin n_bad++; $display("FAIL en_off: got %0d selected want 0", c); end
      bus_a.en = 1'b1;
   endtask

   task automatic test_polarity();
      int first_fs, first_sel, early_sel;
      logic [5:0] sel_cs;
      logic [7:0] sel_seg;
      wait_fs();
      capture(0, 96);
      n_cmp++; if (csb_s[1] !== 6'b000001 || segb_s[1] !== 8'h7F) begin
         n_bad++; $display("FAIL pol_d0: got cs=%b seg=%h want cs=000001 seg=7f", csb_s[1], segb_s[1]);
      end
      n_cmp++; if (csb_s[0] !== 6'b000000 || segb_s[0] !== 8'h00) begin
         n_bad++; $display("FAIL pol_dead: got cs=%b seg=%h want cs=000000 seg=00", csb_s[0], segb_s[0]);
      end
      n_cmp++; if (csb_s[17] !== 6'b000010 || segb_s[17] !== 8'h3F) begin
         n_bad++; $display("FAIL pol_d1: got cs=%b seg=%h want cs=000010 seg=3f", csb_s[17], segb_s[17]);
      end
      wait_fs();
      for (int k = 0; k < 50; k++) tick();
      n_cmp++; if (bus_b.seg_cs !== 6'b001000) begin n_bad++; $display("FAIL pol_pre_rst_cs: got %b want 001000", bus_b.seg_cs); end
      #2 rst_b_ = 1'b0;
      #1;
      n_cmp++; if (bus_b.seg_cs !== 6'b000000) begin n_bad++; $display("FAIL rst_mid_cs: got %b want 000000", bus_b.seg_cs); end
      n_cmp++; if (bus_b.seg_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_seg: got %h want 00", bus_b.seg_data); end
      n_cmp++; if (bus_b.frame_sync !== 1'b0) begin n_bad++; $display("FAIL rst_mid_fs: got %b want 0", bus_b.frame_sync); end
      tick(); tick();
      rst_b_ = 1'b1;
      first_fs = -1; first_sel = -1; early_sel = 0; sel_cs = '0; sel_seg = '0;
      for (int e = 1; e <= 120; e++) begin
         tick();
         if (bus_b.frame_sync === 1'b1 && first_fs < 0) first_fs = e;
         if (bus_b.seg_cs !== 6'b000000 && first_sel < 0) begin
            first_sel = e; sel_cs = bus_b.seg_cs; sel_seg = bus_b.seg_data;
         end
         if (e < 98 && bus_b.seg_cs !== 6'b000000) early_sel++;
      end
      n_cmp++; if (first_fs != 96) begin n_bad++; $display("FAIL rst_mid_fs_cycle: got %0d want 96", first_fs); end
      n_cmp++; if (early_sel != 0) begin n_bad++; $display("FAIL rst_mid_empty: got %0d selected want 0", early_sel); end
      n_cmp++; if (first_sel != 98 || sel_cs !== 6'b000001 || sel_seg !== 8'h7F) begin
         n_bad++; $display("FAIL rst_mid_restart: got cycle=%0d cs=%b seg=%h want cycle=98 cs=000001 seg=7f", first_sel, sel_cs, sel_seg);
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_lz();
      test_pwm();
      test_snapshot_blank();
      test_enable();
      test_polarity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
